// File: rtl/ropes_pkg.sv
// ropes_pkg: shared types, playfield geometry and the two level layout ROMs
// for the rope/vine tile matrix. Arbitration policy macro: ROPES_CTRL_RR_EN.
package ropes_pkg;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        TOP    = 2'd1,
        MID    = 2'd2,
        BOTTOM = 2'd3
    } rope_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SERVE
    } ctrl_state_t;

    localparam int unsigned TILE_LOG2   = 5;
    localparam int unsigned COLS        = 20;
    localparam int unsigned ROWS        = 15;
    localparam int unsigned LOAD_CYCLES = 300;

    // Requester slots in arbitration order: write first, then player, then enemy.
    localparam int unsigned NUM_REQ = 3;
    localparam int unsigned REQ_WR  = 0;
    localparam int unsigned REQ_PL  = 1;
    localparam int unsigned REQ_EN  = 2;

    localparam int unsigned NUM_SEGS = 5;

    typedef logic [LOAD_CYCLES-1:0][1:0] level_rom_t;

    // One vertical rope: column, top row and bottom row (inclusive).
    typedef struct packed {
        logic       valid;
        logic [4:0] col;
        logic [3:0] top;
        logic [3:0] bot;
    } rope_seg_t;

    function automatic rope_seg_t rope_seg(input logic lvl, input int unsigned r);
        rope_seg_t s;
        s = '0;
        if (!lvl) begin
            case (r)
                0: s = '{1'b1, 5'd3,  4'd1, 4'd10};
                1: s = '{1'b1, 5'd8,  4'd0, 4'd6};
                2: s = '{1'b1, 5'd13, 4'd4, 4'd14};
                3: s = '{1'b1, 5'd17, 4'd2, 4'd8};
                default: s = '0;
            endcase
        end else begin
            case (r)
                0: s = '{1'b1, 5'd1,  4'd3, 4'd12};
                1: s = '{1'b1, 5'd6,  4'd0, 4'd9};
                2: s = '{1'b1, 5'd10, 4'd5, 4'd14};
                3: s = '{1'b1, 5'd15, 4'd1, 4'd7};
                4: s = '{1'b1, 5'd19, 4'd2, 4'd11};
                default: s = '0;
            endcase
        end
        return s;
    endfunction

    function automatic level_rom_t build_level(input logic lvl);
        level_rom_t rom;
        rope_seg_t  seg;
        logic [8:0] idx;
        rom = '0;
        for (int unsigned r = 0; r < NUM_SEGS; r++) begin
            seg = rope_seg(lvl, r);
            if (seg.valid) begin
                for (int unsigned row = 32'(seg.top); row <= 32'(seg.bot); row++) begin
                    idx = 9'(row * COLS + 32'(seg.col));
                    if (row == 32'(seg.top))      rom[idx] = TOP;
                    else if (row == 32'(seg.bot)) rom[idx] = BOTTOM;
                    else                          rom[idx] = MID;
                end
            end
        end
        return rom;
    endfunction

    localparam level_rom_t LEVEL0_ROM = build_level(1'b0);
    localparam level_rom_t LEVEL1_ROM = build_level(1'b1);

    function automatic rope_t rom_cell(input logic lvl, input logic [8:0] idx);
        return rope_t'(lvl ? LEVEL1_ROM[idx] : LEVEL0_ROM[idx]);
    endfunction

    function automatic logic in_range(input logic [5:0] col, input logic [5:0] row);
        return (32'(col) < COLS) && (32'(row) < ROWS);
    endfunction

    // Row-major cell index; out-of-range coordinates map to 0 so reads stay in bounds.
    function automatic logic [8:0] cell_index(input logic [5:0] col, input logic [5:0] row);
        return in_range(col, row) ? 9'(32'(row) * COLS + 32'(col)) : '0;
    endfunction

endpackage

// File: rtl/ropes_req_arbiter.sv
// ropes_req_arbiter: picks one of write/player/enemy for the matrix slot.
// ROPES_CTRL_RR_EN selects round-robin; otherwise fixed priority wr > pl > en.
module ropes_req_arbiter
    import ropes_pkg::*;
(
`ifdef ROPES_CTRL_RR_EN
    input  logic               clk,
    input  logic               rst_n,
`endif
    input  logic               enable,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt
);

    logic [1:0] ptr;

`ifdef ROPES_CTRL_RR_EN
    // Pointer moves to the slot after the last granted requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 2'd0;
        end else if (gnt[REQ_WR]) begin
            ptr <= 2'd1;
        end else if (gnt[REQ_PL]) begin
            ptr <= 2'd2;
        end else if (gnt[REQ_EN]) begin
            ptr <= 2'd0;
        end
    end
`else
    assign ptr = 2'd0;
`endif

    // Scan requesters starting at the pointer; first active one wins.
    always_comb begin
        logic       found;
        logic [1:0] k;
        gnt   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            k = 2'((32'(ptr) + i) % NUM_REQ);
            if (enable && !found && req[k]) begin
                gnt[k] = 1'b1;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ropes_matrix_ctrl.sv
// ropes_matrix_ctrl: owns the rope tile matrix, loads levels from ROM, serves
// renderer lookups and arbitrates game-logic reads/writes.
// Arbitration policy macro: ROPES_CTRL_RR_EN (round-robin when defined).
module ropes_matrix_ctrl
    import ropes_pkg::*;
(
    input  logic        clk,
    input  logic        resetN,
    input  logic        loadReq,
    input  logic        levelSel,
    output logic        busy,
    output logic        loadDone,
    input  logic        renderEn,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    output logic [1:0]  tileType,
    output logic        tileValid,
    output logic [4:0]  tileOffsetX,
    output logic [4:0]  tileOffsetY,
    input  logic        plReq,
    input  logic [4:0]  plCol,
    input  logic [3:0]  plRow,
    output logic        plGnt,
    input  logic        enReq,
    input  logic [4:0]  enCol,
    input  logic [3:0]  enRow,
    output logic        enGnt,
    input  logic        wrReq,
    input  logic [4:0]  wrCol,
    input  logic [3:0]  wrRow,
    input  logic [1:0]  wrType,
    output logic        wrGnt,
    output logic [1:0]  rdData,
    output logic        rdValid,
    output logic        rdOwner
);

    ctrl_state_t state, state_next;
    logic        load_start;
    logic        load_last;
    logic [8:0]  load_idx;
    logic        load_level;
    logic        load_done;

    rope_t       cells [LOAD_CYCLES];

    logic [NUM_REQ-1:0] req_vec, gnt_vec;
    logic               arb_enable;

    logic [5:0] rnd_col, rnd_row;
    logic       rnd_in;
    logic [8:0] rnd_idx;

    logic [4:0] rd_col;
    logic [3:0] rd_row;
    logic       rd_in;
    logic [8:0] rd_idx;
    logic       rd_gnt;

    logic       wr_in;
    logic [8:0] wr_idx;

    rope_t      tile_type;
    logic       tile_valid;
    logic [4:0] off_x, off_y;
    rope_t      rd_data;
    logic       rd_valid;
    logic       rd_owner;

    assign load_last = (state == ST_LOAD) && (load_idx == 9'(LOAD_CYCLES - 1));

    // Control state register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: loads run a fixed cell count, loadReq is ignored mid-load.
    always_comb begin
        state_next = state;
        load_start = 1'b0;
        case (state)
            ST_IDLE: begin
                if (loadReq) begin
                    state_next = ST_LOAD;
                    load_start = 1'b1;
                end
            end
            ST_LOAD: begin
                if (load_last) begin
                    state_next = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (loadReq) begin
                    state_next = ST_LOAD;
                    load_start = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Load cursor, sampled level and completion pulse.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            load_idx   <= '0;
            load_level <= 1'b0;
            load_done  <= 1'b0;
        end else begin
            load_done <= load_last;
            if (load_start) begin
                load_idx   <= '0;
                load_level <= levelSel;
            end else if (state == ST_LOAD) begin
                load_idx <= load_idx + 9'd1;
            end
        end
    end

    assign req_vec    = {enReq, plReq, wrReq};
    assign arb_enable = (state == ST_SERVE) && !renderEn;

    ropes_req_arbiter u_arbiter (
`ifdef ROPES_CTRL_RR_EN
        .clk    (clk),
        .rst_n  (resetN),
`endif
        .enable (arb_enable),
        .req    (req_vec),
        .gnt    (gnt_vec)
    );

    assign wrGnt = gnt_vec[REQ_WR];
    assign plGnt = gnt_vec[REQ_PL];
    assign enGnt = gnt_vec[REQ_EN];

    assign wr_in  = in_range({1'b0, wrCol}, {2'b0, wrRow});
    assign wr_idx = cell_index({1'b0, wrCol}, {2'b0, wrRow});

    // Matrix storage: ROM copy during load, granted in-range writes while serving.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int unsigned i = 0; i < LOAD_CYCLES; i++) begin
                cells[i] <= NONE;
            end
        end else if (state == ST_LOAD) begin
            cells[load_idx] <= rom_cell(load_level, load_idx);
        end else if (gnt_vec[REQ_WR] && wr_in) begin
            cells[wr_idx] <= rope_t'(wrType);
        end
    end

    assign rnd_col = pixelX[10:TILE_LOG2];
    assign rnd_row = pixelY[10:TILE_LOG2];
    assign rnd_in  = in_range(rnd_col, rnd_row);
    assign rnd_idx = cell_index(rnd_col, rnd_row);

    // Renderer lookup, one cycle latency; nothing is visible until SERVE.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            tile_type  <= NONE;
            tile_valid <= 1'b0;
            off_x      <= '0;
            off_y      <= '0;
        end else begin
            tile_type  <= (state == ST_SERVE && rnd_in) ? cells[rnd_idx] : NONE;
            tile_valid <= renderEn && (state == ST_SERVE) && rnd_in && (cells[rnd_idx] != NONE);
            off_x      <= pixelX[TILE_LOG2-1:0];
            off_y      <= pixelY[TILE_LOG2-1:0];
        end
    end

    assign rd_gnt = gnt_vec[REQ_PL] || gnt_vec[REQ_EN];
    assign rd_col = gnt_vec[REQ_EN] ? enCol : plCol;
    assign rd_row = gnt_vec[REQ_EN] ? enRow : plRow;
    assign rd_in  = in_range({1'b0, rd_col}, {2'b0, rd_row});
    assign rd_idx = cell_index({1'b0, rd_col}, {2'b0, rd_row});

    // Read result registered one cycle after the grant; data holds between reads.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rd_data  <= NONE;
            rd_valid <= 1'b0;
            rd_owner <= 1'b0;
        end else begin
            rd_valid <= rd_gnt;
            if (rd_gnt) begin
                rd_owner <= gnt_vec[REQ_EN];
                rd_data  <= rd_in ? cells[rd_idx] : NONE;
            end
        end
    end

    assign busy        = (state == ST_LOAD);
    assign loadDone    = load_done;
    assign tileType    = tile_type;
    assign tileValid   = tile_valid;
    assign tileOffsetX = off_x;
    assign tileOffsetY = off_y;
    assign rdData      = rd_data;
    assign rdValid     = rd_valid;
    assign rdOwner     = rd_owner;

endmodule

// File: tb/tb_ropes_matrix_ctrl.sv
// tb_ropes_matrix_ctrl: table-driven, directed and random checks of
// ropes_matrix_ctrl against a behavioural model. Honours ROPES_CTRL_RR_EN.
module tb_ropes_matrix_ctrl;
    import ropes_pkg::*;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        loadReq = 1'b0, levelSel = 1'b0, renderEn = 1'b0;
    logic [10:0] pixelX = '0, pixelY = '0;
    logic        plReq = 1'b0, enReq = 1'b0, wrReq = 1'b0;
    logic [4:0]  plCol = '0, enCol = '0, wrCol = '0;
    logic [3:0]  plRow = '0, enRow = '0, wrRow = '0;
    logic [1:0]  wrType = '0;
    logic        busy, loadDone, tileValid, plGnt, enGnt, wrGnt, rdValid, rdOwner;
    logic [1:0]  tileType, rdData;
    logic [4:0]  tileOffsetX, tileOffsetY;

    ropes_matrix_ctrl dut (
        .clk(clk), .resetN(resetN), .loadReq(loadReq), .levelSel(levelSel),
        .busy(busy), .loadDone(loadDone), .renderEn(renderEn),
        .pixelX(pixelX), .pixelY(pixelY), .tileType(tileType), .tileValid(tileValid),
        .tileOffsetX(tileOffsetX), .tileOffsetY(tileOffsetY),
        .plReq(plReq), .plCol(plCol), .plRow(plRow), .plGnt(plGnt),
        .enReq(enReq), .enCol(enCol), .enRow(enRow), .enGnt(enGnt),
        .wrReq(wrReq), .wrCol(wrCol), .wrRow(wrRow), .wrType(wrType), .wrGnt(wrGnt),
        .rdData(rdData), .rdValid(rdValid), .rdOwner(rdOwner)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Behavioural model: mode 0 idle, 1 loading, 2 serving.
    int   m_mode, m_cnt, m_last;
    logic m_lvl;
    int   m_mat [300];
    int   e_rd_data, e_rd_valid, e_rd_owner;
    int   e_type, e_valid, e_offx, e_offy, e_done;
    logic e_type_chk;
    logic [2:0] g_obs;

    task automatic chk(input string name, input int actual, input int expected);
        n_total++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 300; i++) m_mat[i] = 0;
        m_mode = 0; m_cnt = 0; m_lvl = 1'b0; m_last = 2;
        e_rd_data = 0;
    endtask

    // Expected one-hot grant {en,pl,wr} from the current inputs.
    function automatic logic [2:0] exp_gnt();
        logic [2:0] r;
        int start, k;
        r = {enReq, plReq, wrReq};
        if (m_mode != 2 || renderEn) return 3'b000;
`ifdef ROPES_CTRL_RR_EN
        start = (m_last + 1) % 3;
`else
        start = 0;
`endif
        for (int i = 0; i < 3; i++) begin
            k = (start + i) % 3;
            if (r[k]) return 3'(1 << k);
        end
        return 3'b000;
    endfunction

    // One clock: check grants mid-cycle, advance model, check registered outputs.
    task automatic cycle();
        logic [2:0] eg;
        int col, row, t;
        eg = exp_gnt();
        @(negedge clk);
        g_obs = {enGnt, plGnt, wrGnt};
        chk("wr_gnt", wrGnt, eg[0]);
        chk("pl_gnt", plGnt, eg[1]);
        chk("en_gnt", enGnt, eg[2]);
        if (eg[1] || eg[2]) begin
            col = eg[2] ? int'(enCol) : int'(plCol);
            row = eg[2] ? int'(enRow) : int'(plRow);
            e_rd_valid = 1; e_rd_owner = eg[2];
            e_rd_data = (col < 20 && row < 15) ? m_mat[row * 20 + col] : 0;
        end else begin
            e_rd_valid = 0;
        end
        col = int'(pixelX) / 32; row = int'(pixelY) / 32;
        e_offx = int'(pixelX) % 32; e_offy = int'(pixelY) % 32;
        t = (m_mode == 2 && col < 20 && row < 15) ? m_mat[row * 20 + col] : 0;
        e_type = t;
        e_type_chk = renderEn || (m_mode != 2);
        e_valid = (renderEn && t != 0) ? 1 : 0;
        e_done = (m_mode == 1 && m_cnt == 299) ? 1 : 0;
        if (eg[0] && wrCol < 20 && wrRow < 15) m_mat[int'(wrRow) * 20 + int'(wrCol)] = int'(wrType);
        if (eg[0]) m_last = 0; else if (eg[1]) m_last = 1; else if (eg[2]) m_last = 2;
        case (m_mode)
            1: begin
                m_mat[m_cnt] = int'(rom_cell(m_lvl, 9'(m_cnt)));
                m_cnt++;
                if (m_cnt == 300) m_mode = 2;
            end
            default: if (loadReq) begin m_mode = 1; m_cnt = 0; m_lvl = levelSel; end
        endcase
        @(posedge clk); #1;
        chk("busy", busy, (m_mode == 1) ? 1 : 0);
        chk("load_done", loadDone, e_done);
        chk("tile_valid", tileValid, e_valid);
        if (e_type_chk) chk("tile_type", tileType, e_type);
        chk("off_x", tileOffsetX, e_offx);
        chk("off_y", tileOffsetY, e_offy);
        chk("rd_valid", rdValid, e_rd_valid);
        if (e_rd_valid != 0) begin
            chk("rd_data", rdData, e_rd_data);
            chk("rd_owner", rdOwner, e_rd_owner);
        end
    endtask

    task automatic idle_inputs();
        loadReq = 1'b0; renderEn = 1'b1; plReq = 1'b0; enReq = 1'b0; wrReq = 1'b0;
    endtask

    task automatic rand_drive(input logic [2:0] g);
        renderEn = ($urandom_range(0, 3) == 0);
        loadReq  = ($urandom_range(0, 299) == 0);
        levelSel = 1'($urandom_range(0, 1));
        pixelX   = 11'($urandom_range(0, 700));
        pixelY   = 11'($urandom_range(0, 520));
        if (g[0] || !wrReq) begin
            wrReq = 1'($urandom_range(0, 1)); wrCol = 5'($urandom_range(0, 31));
            wrRow = 4'($urandom_range(0, 15)); wrType = 2'($urandom_range(0, 3));
        end else if ($urandom_range(0, 7) == 0) wrReq = 1'b0;
        if (g[1] || !plReq) begin
            plReq = 1'($urandom_range(0, 1)); plCol = 5'($urandom_range(0, 31));
            plRow = 4'($urandom_range(0, 15));
        end else if ($urandom_range(0, 7) == 0) plReq = 1'b0;
        if (g[2] || !enReq) begin
            enReq = 1'($urandom_range(0, 1)); enCol = 5'($urandom_range(0, 31));
            enRow = 4'($urandom_range(0, 15));
        end else if ($urandom_range(0, 7) == 0) enReq = 1'b0;
    endtask

    typedef struct {
        logic en; int px; int py; int ttype; int tvalid; int offx; int offy; logic chk_type;
    } rvec_t;

    rvec_t      rtab [10];
    logic [2:0] seq_exp [6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt, done_cnt, gnt_cnt;

        // Level 0 layout: col 3 rows 1..10, col 13 rows 4..14, col 17 rows 2..8.
        rtab[0] = '{1'b1, 100,  70, 2, 1,  4,  6, 1'b1};
        rtab[1] = '{1'b1,  96,  32, 1, 1,  0,  0, 1'b1};
        rtab[2] = '{1'b1, 127, 351, 3, 1, 31, 31, 1'b1};
        rtab[3] = '{1'b1, 650,  70, 0, 0, 10,  6, 1'b1};
        rtab[4] = '{1'b1, 100, 480, 0, 0,  4,  0, 1'b1};
        rtab[5] = '{1'b1,   0,   0, 0, 0,  0,  0, 1'b1};
        rtab[6] = '{1'b1, 420, 140, 1, 1,  4, 12, 1'b1};
        rtab[7] = '{1'b0, 100,  70, 0, 0,  4,  6, 1'b0};
        rtab[8] = '{1'b1, 544, 255, 2, 1,  0, 31, 1'b1};
        rtab[9] = '{1'b1, 639, 479, 0, 0, 31, 31, 1'b1};
`ifdef ROPES_CTRL_RR_EN
        seq_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`else
        seq_exp = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
`endif

        // Reset values.
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_load_done", loadDone, 0);
        chk("rst_tile_type", tileType, 0);
        chk("rst_tile_valid", tileValid, 0);
        chk("rst_gnts", {enGnt, plGnt, wrGnt}, 0);
        chk("rst_rd_valid", rdValid, 0);
        resetN = 1'b1;

        // IDLE: nothing granted, nothing visible.
        renderEn = 1'b0; plReq = 1'b1; wrReq = 1'b1; pixelX = 11'd100; pixelY = 11'd70;
        repeat (4) cycle();
        idle_inputs();

        // Reset in the middle of a load aborts it.
        loadReq = 1'b1; levelSel = 1'b1; cycle(); loadReq = 1'b0;
        repeat (100) cycle();
        resetN = 1'b0; #1;
        chk("midload_rst_busy", busy, 0);
        @(posedge clk); #1;
        chk("midload_rst_done", loadDone, 0);
        resetN = 1'b1; model_reset();
        repeat (3) cycle();

        // Full load of level 0.
        loadReq = 1'b1; levelSel = 1'b0; cycle(); loadReq = 1'b0;
        busy_cnt = int'(busy); done_cnt = int'(loadDone);
        repeat (305) begin
            cycle();
            busy_cnt += int'(busy);
            done_cnt += int'(loadDone);
        end
        chk("load_busy_cycles", busy_cnt, 300);
        chk("load_done_pulses", done_cnt, 1);

        // Render lookup table.
        for (int i = 0; i < 10; i++) begin
            renderEn = rtab[i].en; pixelX = 11'(rtab[i].px); pixelY = 11'(rtab[i].py);
            cycle();
            if (rtab[i].chk_type) chk("tbl_type", tileType, rtab[i].ttype);
            chk("tbl_valid", tileValid, rtab[i].tvalid);
            chk("tbl_offx", tileOffsetX, rtab[i].offx);
            chk("tbl_offy", tileOffsetY, rtab[i].offy);
        end

        // Render owns the slot; player read lands once blanking starts.
        renderEn = 1'b1; plReq = 1'b1; plCol = 5'd3; plRow = 4'd2;
        repeat (2) begin cycle(); chk("render_blocks_pl", g_obs, 3'b000); end
        renderEn = 1'b0; cycle();
        chk("pl_gnt_blank", g_obs, 3'b010);
        chk("pl_rd_valid", rdValid, 1);
        chk("pl_rd_owner", rdOwner, 0);
        chk("cell_3_2", rdData, int'(rom_cell(1'b0, 9'd43)));
        plReq = 1'b0;

        // Write then read, and out-of-range write dropped.
        wrReq = 1'b1; wrCol = 5'd5; wrRow = 4'd5; wrType = 2'd2; cycle();
        chk("wr_gnt_5_5", g_obs, 3'b001);
        wrReq = 1'b0; plReq = 1'b1; plCol = 5'd5; plRow = 4'd5; cycle();
        chk("rd_after_wr", rdData, 2);
        plReq = 1'b0; wrReq = 1'b1; wrCol = 5'd25; wrRow = 4'd5; wrType = 2'd1; cycle();
        chk("wr_gnt_oor", g_obs, 3'b001);
        wrReq = 1'b0; plReq = 1'b1; plCol = 5'd5; plRow = 4'd6; cycle();
        chk("oor_wr_no_alias", rdData, 0);
        plCol = 5'd25; plRow = 4'd5; cycle();
        chk("oor_rd_gnt", g_obs, 3'b010);
        chk("oor_rd_none", rdData, 0);
        plReq = 1'b0;

        // Enemy read, then all three contend during blanking.
        enReq = 1'b1; enCol = 5'd8; enRow = 4'd3; cycle();
        chk("en_rd_owner", rdOwner, 1);
        chk("en_rd_data", rdData, 2);
        wrReq = 1'b1; wrCol = 5'd5; wrRow = 4'd5; wrType = 2'd2;
        plReq = 1'b1; plCol = 5'd3; plRow = 4'd2;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("arb_seq", g_obs, seq_exp[i]);
        end
        wrReq = 1'b0; cycle();
        chk("arb_after_wr_drop", g_obs, 3'b010);
        plReq = 1'b0; cycle();
        chk("arb_after_pl_drop", g_obs, 3'b100);
        enReq = 1'b0;

        // loadReq while serving: same-cycle grant completes, then requests stall.
        plReq = 1'b1; plCol = 5'd3; plRow = 4'd2; loadReq = 1'b1; levelSel = 1'b1;
        cycle();
        chk("gnt_with_loadreq", g_obs, 3'b010);
        loadReq = 1'b0; gnt_cnt = 0;
        repeat (300) begin cycle(); gnt_cnt += (g_obs != 3'b000) ? 1 : 0; end
        chk("stall_during_load", gnt_cnt, 0);
        chk("load1_done", loadDone, 1);
        cycle();
        chk("gnt_after_load", g_obs, 3'b010);
        plCol = 5'd1; plRow = 4'd3; cycle();
        chk("lvl1_cell_1_3", rdData, 1);
        plReq = 1'b0;

        // Random traffic against the model.
        g_obs = 3'b000;
        repeat (2000) begin
            rand_drive(g_obs);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ropes_matrix_ctrl.md
Name: ropes_matrix_ctrl

Overview:
Owns the rope/vine tile matrix for the playfield and sequences all access to it.
- Loads a level layout from constant ROM.
- Serves per-pixel tile lookups to the rope bitmap renderer (tile type plus in-tile offsets).
- Arbitrates the single matrix access slot between the render path and three game-logic requesters: player collision read, enemy collision read, and tile modify write.

Parameters:
- TILE_LOG2, 5, tile edge is 2^TILE_LOG2 pixels (32)
- COLS, 20, matrix columns
- ROWS, 15, matrix rows

Ports:
- clk  in  1  system clock
- resetN  in  1  async active-low reset
- loadReq  in  1  pulse: start level load
- levelSel  in  1  level layout to load
- busy  out  1  high while LOAD runs
- loadDone  out  1  one-cycle pulse when LOAD completes
- renderEn  in  1  renderer lookup this cycle (active video)
- pixelX  in  11  current pixel column
- pixelY  in  11  current pixel row
- tileType  out  2  looked-up tile type (ropes_pkg::rope_t)
- tileValid  out  1  tileType is non-NONE and in range
- tileOffsetX  out  5  pixelX mod 32, registered with tileType
- tileOffsetY  out  5  pixelY mod 32, registered with tileType
- plReq, plCol[4:0], plRow[3:0]  in  player read request
- plGnt  out  1  player request accepted
- enReq, enCol[4:0], enRow[3:0]  in  enemy read request
- enGnt  out  1  enemy request accepted
- wrReq, wrCol[4:0], wrRow[3:0], wrType[1:0]  in  modify request
- wrGnt  out  1  write accepted
- rdData  out  2  read result
- rdValid  out  1  read result strobe
- rdOwner  out  1  0 = player, 1 = enemy

Behaviour:
- Reset:
  - All matrix cells NONE; FSM IDLE.
  - All outputs 0 (tileType = NONE, busy = 0, gnts = 0, rdValid = 0).
  - Reset mid-LOAD aborts the load; no loadDone pulse.
- FSM states and transitions:
  - IDLE: loadReq -> LOAD.
  - LOAD: one cell per cycle, index 0..COLS*ROWS-1 (row-major), from ROM[levelSel]. Exactly 300 cycles, then SERVE with loadDone pulse. loadReq during LOAD is ignored. levelSel is sampled on entry.
  - SERVE: loadReq -> LOAD, taking effect at the next cycle. A request granted in the same cycle still completes.
- Slot ownership in SERVE:
  - renderEn = 1: render owns the slot; no gnt is issued.
  - renderEn = 0: the arbiter picks one of pl/en/wr. The granted request's gnt is high combinationally for that cycle only.
- Requesters hold req and address stable until gnt. Dropping req before gnt is legal and cancels the request.
- Write timing: the cell is updated at the clock edge of the grant cycle. Any access in a later cycle sees the new value.
- Read timing: rdData, rdValid and rdOwner are registered one cycle after the gnt cycle.
- Render path:
  - col = pixelX >> 5, row = pixelY >> 5.
  - tileType, tileValid and offsets are registered with 1-cycle latency.
  - col >= 20 or row >= 15: tileType = NONE, tileValid = 0.
  - In IDLE or LOAD: tileType = NONE, tileValid = 0.
  - renderEn = 0: tileValid = 0.
- Out-of-range requester address: granted normally. Read returns NONE; write is dropped.
- Requests in IDLE or LOAD are never granted.

Optional Feature:
ROPES_CTRL_RR_EN
- Defined: round-robin arbitration among pl/en/wr. The pointer advances to the requester after the last granted one.
- Undefined: fixed priority wr > pl > en.

Decomposition:
- ropes_pkg:
  - rope_t enum: NONE = 0, TOP = 1, MID = 2, BOTTOM = 3.
  - COLS, ROWS, TILE_LOG2.
  - LOAD_CYCLES = 300.
  - Level ROM constant: two 300-entry rope_t arrays.
- One sub-module: ropes_req_arbiter. Takes 3 reqs, an enable (SERVE && !renderEn), and the macro-selected policy. Outputs a one-hot gnt.

Test Plan:
- Reset, then loadReq with levelSel = 0 -> busy high for exactly 300 cycles; loadDone pulses once; cell (3,2) equals ROM0 entry 43.
- SERVE, renderEn = 1, pixelX = 100, pixelY = 70 -> next cycle tileType = ROM0[2*20+3], tileOffsetX = 4, tileOffsetY = 6.
- Render out of range: pixelX = 650 -> tileValid = 0.
- renderEn = 1 with plReq held -> no plGnt. Drop renderEn -> plGnt that cycle; rdValid with rdOwner = 0 and correct rdData one cycle later.
- Write then read: wrReq (5,5) MID granted, then plReq (5,5) -> rdData = MID. wrReq (25,5) is granted and leaves the matrix unchanged.
- pl, en and wr requests held for 6 blanking cycles:
  - RR_EN defined: grants rotate wr, pl, en, ...
  - RR_EN undefined: wr is granted first; pl then en follow only after wrReq drops.
  - loadReq mid-SERVE -> requests stall until loadDone.
